mem_bus_arbiter: RTL

- Two-master, one-slave arbiter for the NPC memory bus.
- Shares one memory/SRAM request-response port between IFU (master 0) and LSU (master 1).
- Serialises one transaction at a time: grant, request handshake, response handshake, release.
- Sits between the fetch/LSU stage handshakes and the single memory slave.

---
 rtl/mem_bus_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master (IFU=m0, LSU=m1) to one-slave memory bus arbiter, one transaction at a time.
// Define ARB_RR_EN for round-robin tie-breaking; default build gives m1 fixed priority.
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m0_wen,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wmask,
  output logic            m0_resp_valid,
  input  logic            m0_resp_ready,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_resp_err,
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_wen,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wmask,
  output logic            m1_resp_valid,
  input  logic            m1_resp_ready,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_resp_err,
  output logic            s_req_valid,
  input  logic            s_req_ready,
  output logic [AW-1:0]   s_addr,
  output logic            s_wen,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wmask,
  input  logic            s_resp_valid,
  output logic            s_resp_ready,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_resp_err,
  output logic [1:0]      gnt,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_q, last_d;
  logic       win, sel, in_req, in_resp, g_req_valid, g_resp_ready;
  assign sel          = gnt_q[1];
  assign in_req       = state_q == REQ;
  assign in_resp      = state_q == RESP;
  assign g_req_valid  = sel ? m1_req_valid : m0_req_valid;
  assign g_resp_ready = sel ? m1_resp_ready : m0_resp_ready;
  // m1 wins any tie unless round-robin hands it to whoever did not go last
  always_comb begin
    win = m1_req_valid;
`ifdef ARB_RR_EN
    if (m0_req_valid && m1_req_valid) win = ~last_q;
`endif
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    if (state_q == IDLE && (m0_req_valid || m1_req_valid)) begin
      state_d = REQ;
      gnt_d   = win ? 2'b10 : 2'b01;
    end else if (in_req && g_req_valid && s_req_ready) begin
      state_d = RESP;
    end else if (in_resp && s_resp_valid && g_resp_ready) begin
      state_d = IDLE;
      gnt_d   = 2'b00;
      last_d  = sel;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end
  assign s_req_valid   = in_req && g_req_valid;
  assign s_addr        = in_req ? (sel ? m1_addr : m0_addr) : '0;
  assign s_wen         = in_req && (sel ? m1_wen : m0_wen);
  assign s_wdata       = in_req ? (sel ? m1_wdata : m0_wdata) : '0;
  assign s_wmask       = in_req ? (sel ? m1_wmask : m0_wmask) : '0;
  assign m0_req_ready  = in_req && !sel && s_req_ready;
  assign m1_req_ready  = in_req && sel && s_req_ready;
  assign s_resp_ready  = in_resp && g_resp_ready;
  assign m0_resp_valid = in_resp && !sel && s_resp_valid;
  assign m1_resp_valid = in_resp && sel && s_resp_valid;
  assign m0_rdata      = s_rdata;
  assign m1_rdata      = s_rdata;
  assign m0_resp_err   = s_resp_err;
  assign m1_resp_err   = s_resp_err;
  assign gnt           = gnt_q;
  assign busy          = state_q != IDLE;
endmodule
